// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into fixed-width trigger pulses separated by a guaranteed low gap.
// Define PULSE_STRETCHER_RETRIG_EN for retriggerable mode (strobes during HIGH extend the pulse).
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic              clr_ovf,
    output logic              trigger,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    localparam int MAXC  = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  phase;
    logic [CNT_W-1:0]  phase_next;
    logic [PEND_W-1:0] pend_next;
    logic              overflow_next;
    logic              trigger_next;
    logic              busy_next;
    logic              inc;
    logic              consume;
    logic              ovf_event;

    // Every output is a flop so that reset clears them without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            pend_cnt <= '0;
            overflow <= 1'b0;
            trigger  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            pend_cnt <= pend_next;
            overflow <= overflow_next;
            trigger  <= trigger_next;
            busy     <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase;
        inc        = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_next = HIGH;
                    phase_next = '0;
                end
            end
            HIGH: begin
`ifdef PULSE_STRETCHER_RETRIG_EN
                if (pulse_in) begin
                    phase_next = '0;
                end else if (phase == HIGH_LAST) begin
                    state_next = GAP;
                    phase_next = '0;
                end else begin
                    phase_next = phase + CNT_W'(1);
                end
`else
                inc = pulse_in;
                if (phase == HIGH_LAST) begin
                    state_next = GAP;
                    phase_next = '0;
                end else begin
                    phase_next = phase + CNT_W'(1);
                end
`endif
            end
            GAP: begin
                if (phase == GAP_LAST) begin
                    phase_next = '0;
                    if ((pend_cnt != '0) || pulse_in) begin
                        state_next = HIGH;
                        consume    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    inc        = pulse_in;
                    phase_next = phase + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase

        // A launch that coincides with a new strobe swaps one request for another.
        pend_next = pend_cnt;
        ovf_event = 1'b0;
        if (inc) begin
            if (pend_cnt == PEND_MAX) begin
                ovf_event = 1'b1;
            end else begin
                pend_next = pend_cnt + PEND_W'(1);
            end
        end else if (consume && !pulse_in) begin
            pend_next = pend_cnt - PEND_W'(1);
        end

        overflow_next = (overflow && !clr_ovf) || ovf_event;
    end

    always_comb begin
        trigger_next = (state_next == HIGH);
        busy_next    = (state_next != IDLE);
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with default parameters (HIGH=4, GAP=2, PEND_W=2).
// Per-cycle outputs are recorded and compared against hand-derived sequences.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       pulse_in;
    logic       clr_ovf;
    logic       trigger;
    logic       busy;
    logic [1:0] pend_cnt;
    logic       overflow;

    int checks;
    int errors;

    logic [63:0] trig_seq;
    logic [63:0] busy_seq;
    logic [1:0]  pend_rec [64];
    logic        ovf_rec  [64];

    pulse_stretcher #(
        .HIGH_CYCLES(4),
        .GAP_CYCLES (2),
        .PEND_W     (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .clr_ovf (clr_ovf),
        .trigger (trigger),
        .busy    (busy),
        .pend_cnt(pend_cnt),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Element i of each record holds the outputs during the cycle after input cycle i.
    task automatic applyStimulus(input logic [63:0] pin, input logic [63:0] clr, input int n);
        trig_seq = '0;
        busy_seq = '0;
        for (int i = 0; i < n; i++) begin
            pulse_in = pin[i];
            clr_ovf  = clr[i];
            @(posedge clk);
            #1;
            trig_seq[i] = trigger;
            busy_seq[i] = busy;
            pend_rec[i] = pend_cnt;
            ovf_rec[i]  = overflow;
        end
        pulse_in = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    function automatic int countRises(input logic [63:0] s, input int n);
        int   c;
        logic p;
        c = 0;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (s[i] && !p) c++;
            p = s[i];
        end
        return c;
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        pulse_in = 1'b0;
        clr_ovf  = 1'b0;
        #23;
        checkOutput("reset_trigger",  64'(trigger),  64'h0);
        checkOutput("reset_busy",     64'(busy),     64'h0);
        checkOutput("reset_pend",     64'(pend_cnt), 64'h0);
        checkOutput("reset_overflow", 64'(overflow), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(64'h0, 64'h0, 3);
        checkOutput("idle_trigger", trig_seq, 64'h0);

        // single strobe: high 4 cycles, busy through the 2-cycle gap
        applyStimulus(64'h1, 64'h0, 10);
        checkOutput("single_trigger", trig_seq, 64'hF);
        checkOutput("single_busy",    busy_seq, 64'h3F);
        checkOutput("single_pend",    64'(pend_rec[2]), 64'h0);

`ifdef PULSE_STRETCHER_RETRIG_EN
        applyStimulus(64'h15, 64'h0, 14);
        checkOutput("retrig_trigger", trig_seq, 64'hFF);
        checkOutput("retrig_busy",    busy_seq, 64'h3FF);
        checkOutput("retrig_rises",   64'(countRises(trig_seq, 14)), 64'd1);
        checkOutput("retrig_pend3",   64'(pend_rec[3]), 64'h0);
        checkOutput("retrig_pend6",   64'(pend_rec[6]), 64'h0);
`else
        // two strobes: second pulse launches straight from the gap
        applyStimulus(64'h5, 64'h0, 14);
        checkOutput("pair_trigger", trig_seq, 64'h3CF);
        checkOutput("pair_busy",    busy_seq, 64'hFFF);
        checkOutput("pair_rises",   64'(countRises(trig_seq, 14)), 64'd2);
        checkOutput("pair_pend1",   64'(pend_rec[1]), 64'h0);
        checkOutput("pair_pend2",   64'(pend_rec[2]), 64'h1);
        checkOutput("pair_pend5",   64'(pend_rec[5]), 64'h1);
        checkOutput("pair_pend6",   64'(pend_rec[6]), 64'h0);

        // held strobe saturates the queue at 3 and sets overflow
        applyStimulus(64'h3F, 64'h0, 28);
        checkOutput("hold_trigger", trig_seq, 64'h3CF3CF);
        checkOutput("hold_busy",    busy_seq, 64'hFFFFFF);
        checkOutput("hold_rises",   64'(countRises(trig_seq, 28)), 64'd4);
        checkOutput("hold_pend3",   64'(pend_rec[3]),  64'h3);
        checkOutput("hold_pend5",   64'(pend_rec[5]),  64'h3);
        checkOutput("hold_pend6",   64'(pend_rec[6]),  64'h2);
        checkOutput("hold_pend12",  64'(pend_rec[12]), 64'h1);
        checkOutput("hold_pend18",  64'(pend_rec[18]), 64'h0);
        checkOutput("hold_ovf3",    64'(ovf_rec[3]),   64'h0);
        checkOutput("hold_ovf4",    64'(ovf_rec[4]),   64'h1);
        checkOutput("hold_ovf27",   64'(ovf_rec[27]),  64'h1);
        applyStimulus(64'h0, 64'h1, 1);
        checkOutput("clr_ovf",      64'(ovf_rec[0]),   64'h0);

        // clear and a fresh overflow in the same cycle: set wins
        applyStimulus(64'h3F, 64'h60, 28);
        checkOutput("setwins_ovf4", 64'(ovf_rec[4]), 64'h1);
        checkOutput("setwins_ovf5", 64'(ovf_rec[5]), 64'h1);
        checkOutput("setwins_ovf6", 64'(ovf_rec[6]), 64'h0);

        // strobe on the final gap cycle with one request queued
        applyStimulus(64'h45, 64'h0, 20);
        checkOutput("lastgap_trigger", trig_seq, 64'hF3CF);
        checkOutput("lastgap_rises",   64'(countRises(trig_seq, 20)), 64'd3);
        checkOutput("lastgap_pend6",   64'(pend_rec[6]),  64'h1);
        checkOutput("lastgap_pend11",  64'(pend_rec[11]), 64'h1);
        checkOutput("lastgap_pend12",  64'(pend_rec[12]), 64'h0);

        // reset mid-HIGH with two queued requests
        applyStimulus(64'h7, 64'h0, 3);
        checkOutput("prerst_trigger", 64'(trig_seq[2]), 64'h1);
        checkOutput("prerst_pend",    64'(pend_rec[2]), 64'h2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_trigger", 64'(trigger),  64'h0);
        checkOutput("midrst_busy",    64'(busy),     64'h0);
        checkOutput("midrst_pend",    64'(pend_cnt), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(64'h1, 64'h0, 10);
        checkOutput("postrst_trigger", trig_seq, 64'hF);
        checkOutput("postrst_busy",    busy_seq, 64'h3F);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
